// File: rtl/pc_sequencer.sv
// Program-counter sequencer: conditional jumps on ZCSO, call/return via a
// circular return-address stack, one-cycle flush bubble after transfers, halt.
module pc_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        ZCSO,
  input  logic              jump_req,
  input  logic [3:0]        jump_cond,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              stall,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              branch_taken,
  output logic              flush,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic              halted
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_nstate;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_npc;
  logic              r_bt;
  logic              w_nbt;
  logic              r_boot;
  logic              w_nboot;
  logic              r_ovf;
  logic              r_unf;
  logic [PW-1:0]     r_sp;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic              w_push;
  logic              w_pop;
  logic              w_set_unf;
  logic              w_full;
  logic              w_empty;
  logic              w_take;
  logic              w_z;
  logic              w_c;
  logic              w_s;
  logic              w_o;
  logic              w_lt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_top;

  assign w_z      = ZCSO[0];
  assign w_c      = ZCSO[1];
  assign w_s      = ZCSO[2];
  assign w_o      = ZCSO[3];
  assign w_lt     = w_s ^ w_o;
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_full   = (r_cnt == CW'(RAS_DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_top    = r_ras[r_sp - PW'(1)];

  always_comb begin
    w_take = 1'b0;
    case (jump_cond)
      4'b0000: w_take = 1'b1;
      4'b0001: w_take = w_z;
      4'b0010: w_take = !w_z;
      4'b0011: w_take = w_c;
      4'b0100: w_take = !w_c;
      4'b0101: w_take = w_s;
      4'b0110: w_take = !w_s;
      4'b0111: w_take = w_o;
      4'b1000: w_take = !w_o;
      4'b1001: w_take = w_lt;
      4'b1010: w_take = !w_lt;
      4'b1011: w_take = !w_z && !w_lt;
      4'b1100: w_take = w_z || w_lt;
      default: w_take = 1'b0;
    endcase
  end

  // Bubble after reset is held one extra cycle by r_boot; a bubble after a
  // transfer advances past the target, which was presented while flushing.
  always_comb begin
    w_nstate  = r_state;
    w_npc     = r_pc;
    w_nbt     = 1'b0;
    w_nboot   = r_boot;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_unf = 1'b0;
    case (r_state)
      S_FLUSH: begin
        if (r_boot) begin
          w_nboot = 1'b0;
        end else begin
          w_nstate = S_RUN;
          if (r_bt) w_npc = w_pc_inc;
        end
      end
      S_RUN: begin
        priority case (1'b1)
          halt_req: w_nstate = S_HALT;
          ret_req: begin
            if (!w_empty) begin
              w_pop    = 1'b1;
              w_npc    = w_top;
              w_nbt    = 1'b1;
              w_nstate = S_FLUSH;
            end else begin
              w_set_unf = 1'b1;
              w_npc     = w_pc_inc;
            end
          end
          call_req: begin
            w_push   = 1'b1;
            w_npc    = jump_target;
            w_nbt    = 1'b1;
            w_nstate = S_FLUSH;
          end
          jump_req && w_take: begin
            w_npc    = jump_target;
            w_nbt    = 1'b1;
            w_nstate = S_FLUSH;
          end
          default: w_npc = w_pc_inc;
        endcase
      end
      S_HALT: w_nstate = S_HALT;
      default: w_nstate = S_FLUSH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FLUSH;
      r_pc    <= ADDR_W'(RESET_PC);
      r_bt    <= 1'b0;
      r_boot  <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_sp    <= '0;
      r_cnt   <= '0;
    end else if (!stall) begin
      r_state <= w_nstate;
      r_pc    <= w_npc;
      r_bt    <= w_nbt;
      r_boot  <= w_nboot;
      if (w_push) begin
        r_sp  <= r_sp + PW'(1);
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop) begin
        r_sp  <= r_sp - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !stall && w_push) r_ras[r_sp] <= w_pc_inc;
  end

  assign pc            = r_pc;
  assign pc_valid      = (r_state == S_RUN);
  assign flush         = (r_state == S_FLUSH) && !r_boot;
  assign halted        = (r_state == S_HALT);
  assign branch_taken  = r_bt && !stall;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  ZCSO;
  logic        jump_req;
  logic [3:0]  jump_cond;
  logic [15:0] jump_target;
  logic        call_req;
  logic        ret_req;
  logic        stall;
  logic        halt_req;
  logic [15:0] pc;
  logic        pc_valid;
  logic        branch_taken;
  logic        flush;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        halted;

  pc_sequencer #(
    .ADDR_W(16),
    .RESET_PC(0),
    .RAS_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ZCSO(ZCSO),
    .jump_req(jump_req),
    .jump_cond(jump_cond),
    .jump_target(jump_target),
    .call_req(call_req),
    .ret_req(ret_req),
    .stall(stall),
    .halt_req(halt_req),
    .pc(pc),
    .pc_valid(pc_valid),
    .branch_taken(branch_taken),
    .flush(flush),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow),
    .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] pc;
    logic        v;
    logic        fl;
    logic        bt;
    logic        h;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  int   n_cyc  = 0;
  logic e_ov   = 1'b0;
  logic e_un   = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pc, pc_valid, flush, branch_taken, halted,
           ras_overflow, ras_underflow};
      total++;
      n_cyc++;
      if (a === e) passed++;
      else
        $display("FAIL cyc%0d: got pc=%h v=%b fl=%b bt=%b h=%b ov=%b un=%b, expected pc=%h v=%b fl=%b bt=%b h=%b ov=%b un=%b",
                 n_cyc, a.pc, a.v, a.fl, a.bt, a.h, a.ov, a.un,
                 e.pc, e.v, e.fl, e.bt, e.h, e.ov, e.un);
    end
  end

  task automatic tick(input logic [15:0] p, input logic v, input logic fl,
                      input logic bt, input logic h);
    exp_t e;
    e.pc = p;
    e.v  = v;
    e.fl = fl;
    e.bt = bt;
    e.h  = h;
    e.ov = e_ov;
    e.un = e_un;
    @(posedge clock);
    q.push_back(e);
    @(negedge clock);
    #1;
  endtask

  task automatic clr();
    jump_req = 1'b0;
    call_req = 1'b0;
    ret_req  = 1'b0;
    stall    = 1'b0;
    halt_req = 1'b0;
  endtask

  task automatic jt(input logic [3:0] c, input logic [15:0] t);
    jump_req    = 1'b1;
    jump_cond   = c;
    jump_target = t;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    ZCSO        = 4'b0000;
    jump_cond   = 4'b0000;
    jump_target = 16'h0000;
    clr();

    tick(16'h0000, 0, 0, 0, 0);
    reset = 1'b0;
    tick(16'h0000, 0, 1, 0, 0);
    for (int i = 0; i <= 5; i++) tick(16'(i), 1, 0, 0, 0);

    ZCSO = 4'b0001;
    jt(4'b0001, 16'h0040);
    tick(16'h0040, 0, 1, 1, 0);
    clr();
    tick(16'h0041, 1, 0, 0, 0);
    jt(4'b0000, 16'h0004);
    tick(16'h0004, 0, 1, 1, 0);
    clr();
    tick(16'h0005, 1, 0, 0, 0);
    jt(4'b0010, 16'h0040);
    tick(16'h0006, 1, 0, 0, 0);
    clr();

    ZCSO = 4'b0100;
    jt(4'b1001, 16'h0100);
    tick(16'h0100, 0, 1, 1, 0);
    clr();
    tick(16'h0101, 1, 0, 0, 0);
    jt(4'b1010, 16'h0200);
    tick(16'h0102, 1, 0, 0, 0);
    jt(4'b1100, 16'h0300);
    tick(16'h0300, 0, 1, 1, 0);
    clr();
    tick(16'h0301, 1, 0, 0, 0);
    jt(4'b1011, 16'h0400);
    tick(16'h0302, 1, 0, 0, 0);
    jt(4'b1110, 16'h0500);
    tick(16'h0303, 1, 0, 0, 0);
    clr();

    jt(4'b0000, 16'h000F);
    tick(16'h000F, 0, 1, 1, 0);
    clr();
    tick(16'h0010, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      call_req    = 1'b1;
      jump_target = 16'(i * 16 + 15);
      if (i == 5) e_ov = 1'b1;
      tick(16'(i * 16 + 15), 0, 1, 1, 0);
      clr();
      tick(16'(i * 16 + 16), 1, 0, 0, 0);
    end
    for (int i = 5; i >= 2; i--) begin
      ret_req = 1'b1;
      tick(16'(i * 16 + 1), 0, 1, 1, 0);
      clr();
      tick(16'(i * 16 + 2), 1, 0, 0, 0);
    end
    ret_req = 1'b1;
    e_un    = 1'b1;
    tick(16'h0023, 1, 0, 0, 0);
    clr();
    tick(16'h0024, 1, 0, 0, 0);

    call_req    = 1'b1;
    jump_req    = 1'b1;
    jump_cond   = 4'b0000;
    jump_target = 16'h0700;
    stall       = 1'b1;
    repeat (3) tick(16'h0024, 1, 0, 0, 0);
    stall = 1'b0;
    tick(16'h0700, 0, 1, 1, 0);
    clr();
    tick(16'h0701, 1, 0, 0, 0);

    jt(4'b0000, 16'h0006);
    tick(16'h0006, 0, 1, 1, 0);
    clr();
    tick(16'h0007, 1, 0, 0, 0);
    halt_req = 1'b1;
    jt(4'b0000, 16'h0900);
    tick(16'h0007, 0, 0, 0, 1);
    clr();
    tick(16'h0007, 0, 0, 0, 1);
    jt(4'b0000, 16'h0900);
    ret_req = 1'b1;
    tick(16'h0007, 0, 0, 0, 1);
    clr();

    reset = 1'b1;
    e_ov  = 1'b0;
    e_un  = 1'b0;
    tick(16'h0000, 0, 0, 0, 0);
    reset = 1'b0;
    tick(16'h0000, 0, 1, 0, 0);
    tick(16'h0000, 1, 0, 0, 0);

    jt(4'b0000, 16'hFFFE);
    tick(16'hFFFE, 0, 1, 1, 0);
    clr();
    tick(16'hFFFF, 1, 0, 0, 0);
    tick(16'h0000, 1, 0, 0, 0);
    tick(16'h0001, 1, 0, 0, 0);
    ret_req = 1'b1;
    e_un    = 1'b1;
    tick(16'h0002, 1, 0, 0, 0);
    clr();

    call_req    = 1'b1;
    jump_target = 16'h0055;
    tick(16'h0055, 0, 1, 1, 0);
    clr();
    reset = 1'b1;
    e_un  = 1'b0;
    tick(16'h0000, 0, 0, 0, 0);
    reset = 1'b0;
    tick(16'h0000, 0, 1, 0, 0);
    tick(16'h0000, 1, 0, 0, 0);
    ret_req = 1'b1;
    e_un    = 1'b1;
    tick(16'h0001, 1, 0, 0, 0);
    clr();
    tick(16'h0002, 1, 0, 0, 0);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expected cycles never observed, required 0",
               q.size());
      total += q.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
